// File: rtl/psum_line_accumulator_pkg.sv
// Shared constants, config-field positions and helpers for the psum line accumulator.
package psum_line_accumulator_pkg;

  localparam int BIT_WIDTH_DEF  = 8;
  localparam int ACC_WIDTH_DEF  = 16;
  localparam int NUM_KERNEL_DEF = 4;
  localparam int LINE_DEPTH_DEF = 64;
  localparam int POS_WIDTH_DEF  = 6;
  localparam int REG_WIDTH_DEF  = 32;
  localparam int PASS_WIDTH_DEF = 8;

  // o_err bit positions
  localparam int ERR_DROP  = 0;
  localparam int ERR_CLAMP = 1;

  // config register field positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int OSHAPE_MSB    = 7;
  localparam int OSHAPE_LSB    = 0;
  localparam int NUMPASS_MSB   = 7;
  localparam int NUMPASS_LSB   = 0;

  // Latched per-frame geometry shared by all lanes.
  typedef struct packed {
    logic [POS_WIDTH_DEF-1:0]  w;
    logic [PASS_WIDTH_DEF-1:0] p;
  } frame_cfg_t;

  // Widen a signed psum to accumulator width.
  function automatic logic [ACC_WIDTH_DEF-1:0] sign_extend(input logic [BIT_WIDTH_DEF-1:0] v);
    return {{(ACC_WIDTH_DEF-BIT_WIDTH_DEF){v[BIT_WIDTH_DEF-1]}}, v};
  endfunction

endpackage

// File: rtl/psum_line_accumulator_if.sv
// Psum input streams and accumulated output streams for the four kernel lanes.
interface psum_line_accumulator_if #(
  parameter int BIT_WIDTH = 8,
  parameter int ACC_WIDTH = 16
);
  logic [BIT_WIDTH-1:0] i_psum_kn0;
  logic [BIT_WIDTH-1:0] i_psum_kn1;
  logic [BIT_WIDTH-1:0] i_psum_kn2;
  logic [BIT_WIDTH-1:0] i_psum_kn3;
  logic                 i_psum_kn0_val;
  logic                 i_psum_kn1_val;
  logic                 i_psum_kn2_val;
  logic                 i_psum_kn3_val;
  logic [ACC_WIDTH-1:0] o_acc_kn0;
  logic [ACC_WIDTH-1:0] o_acc_kn1;
  logic [ACC_WIDTH-1:0] o_acc_kn2;
  logic [ACC_WIDTH-1:0] o_acc_kn3;
  logic                 o_acc_kn0_val;
  logic                 o_acc_kn1_val;
  logic                 o_acc_kn2_val;
  logic                 o_acc_kn3_val;

  modport master (
    output i_psum_kn0, i_psum_kn1, i_psum_kn2, i_psum_kn3,
    output i_psum_kn0_val, i_psum_kn1_val, i_psum_kn2_val, i_psum_kn3_val,
    input  o_acc_kn0, o_acc_kn1, o_acc_kn2, o_acc_kn3,
    input  o_acc_kn0_val, o_acc_kn1_val, o_acc_kn2_val, o_acc_kn3_val
  );

  modport slave (
    input  i_psum_kn0, i_psum_kn1, i_psum_kn2, i_psum_kn3,
    input  i_psum_kn0_val, i_psum_kn1_val, i_psum_kn2_val, i_psum_kn3_val,
    output o_acc_kn0, o_acc_kn1, o_acc_kn2, o_acc_kn3,
    output o_acc_kn0_val, o_acc_kn1_val, o_acc_kn2_val, o_acc_kn3_val
  );
endinterface

// File: rtl/psum_line_accumulator_lane.sv
// One kernel lane: line memory, position/pass counters, adder, output register
// and the frame-finished flag. Lanes run independently of each other.
module psum_lane_accumulator
  import psum_line_accumulator_pkg::*;
#(
  parameter int BIT_WIDTH  = BIT_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int LINE_DEPTH = LINE_DEPTH_DEF,
  parameter int POS_WIDTH  = POS_WIDTH_DEF,
  parameter int PASS_WIDTH = PASS_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [BIT_WIDTH-1:0]  psum,
  input  logic                  psum_val,
  input  logic [POS_WIDTH-1:0]  w,
  input  logic [PASS_WIDTH-1:0] p,
  input  logic                  done_clr,
  output logic [ACC_WIDTH-1:0]  acc,
  output logic                  acc_val,
  output logic                  lane_done,
  output logic                  active
);

  logic [ACC_WIDTH-1:0]  mem_r [LINE_DEPTH];
  logic [POS_WIDTH-1:0]  pos_r;
  logic [PASS_WIDTH-1:0] pass_r;
  logic [ACC_WIDTH-1:0]  acc_r;
  logic                  acc_val_r;
  logic                  lane_done_r;

  logic [ACC_WIDTH-1:0]  ext_s;
  logic [ACC_WIDTH-1:0]  rd_s;
  logic [ACC_WIDTH-1:0]  sum_s;
  logic                  last_pos_s;
  logic                  last_pass_s;
  logic [POS_WIDTH-1:0]  pos_nxt_s;
  logic [PASS_WIDTH-1:0] pass_nxt_s;
  logic                  wr_s;
  logic                  finish_s;

  // Adder and counter next-state; the memory read is combinational so a
  // write in one cycle is visible to a psum hitting the same slot next cycle.
  always_comb begin
    ext_s       = sign_extend(psum);
    rd_s        = mem_r[pos_r];
    last_pos_s  = (pos_r == w);
    last_pass_s = (pass_r == p);
    wr_s        = en & psum_val;
    if (pass_r == {PASS_WIDTH{1'b0}}) begin
      sum_s = ext_s;
    end else begin
      sum_s = rd_s + ext_s;
    end
    if (last_pos_s) begin
      pos_nxt_s = {POS_WIDTH{1'b0}};
      if (last_pass_s) begin
        pass_nxt_s = {PASS_WIDTH{1'b0}};
      end else begin
        pass_nxt_s = pass_r + PASS_WIDTH'(1);
      end
    end else begin
      pos_nxt_s  = pos_r + POS_WIDTH'(1);
      pass_nxt_s = pass_r;
    end
    finish_s = wr_s & last_pos_s & last_pass_s;
  end

  // Counters, output register and frame-finished flag; disable acts as a soft clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_r       <= {POS_WIDTH{1'b0}};
      pass_r      <= {PASS_WIDTH{1'b0}};
      acc_r       <= {ACC_WIDTH{1'b0}};
      acc_val_r   <= 1'b0;
      lane_done_r <= 1'b0;
    end else if (!en) begin
      pos_r       <= {POS_WIDTH{1'b0}};
      pass_r      <= {PASS_WIDTH{1'b0}};
      acc_val_r   <= 1'b0;
      lane_done_r <= 1'b0;
    end else begin
      if (wr_s) begin
        pos_r  <= pos_nxt_s;
        pass_r <= pass_nxt_s;
      end
      if (wr_s && last_pass_s) begin
        acc_r <= sum_s;
      end
      acc_val_r <= wr_s & last_pass_s;
      // a new finish wins over the global clear so a fast lane is never lost
      lane_done_r <= finish_s | (lane_done_r & ~done_clr);
    end
  end

  // Line memory write of the running partial sum (contents need no reset).
  always_ff @(posedge clk) begin
    if (wr_s && !rst) begin
      mem_r[pos_r] <= sum_s;
    end
  end

  assign acc       = acc_r;
  assign acc_val   = acc_val_r;
  assign lane_done = lane_done_r;
  assign active    = (pos_r != {POS_WIDTH{1'b0}}) | (pass_r != {PASS_WIDTH{1'b0}});

endmodule

// File: rtl/psum_line_accumulator.sv
// Multi-pass psum accumulator: config latch with width clamp, sticky errors,
// frame-done aggregation and four independent lane accumulators.
module psum_line_accumulator
  import psum_line_accumulator_pkg::*;
#(
  parameter int BIT_WIDTH  = BIT_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int NUM_KERNEL = NUM_KERNEL_DEF,
  parameter int LINE_DEPTH = LINE_DEPTH_DEF,
  parameter int POS_WIDTH  = POS_WIDTH_DEF,
  parameter int REG_WIDTH  = REG_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  psum_line_accumulator_if.slave bus,
  input  logic [REG_WIDTH-1:0]  i_conf_ctrl,
  input  logic [REG_WIDTH-1:0]  i_conf_outputshape,
  input  logic [REG_WIDTH-1:0]  i_conf_numpass,
  output logic                  o_done,
  output logic                  o_busy,
  output logic [1:0]            o_err
);

  localparam int PASS_WIDTH = PASS_WIDTH_DEF;

  logic                                   en_s;
  logic                                   en_d_r;
  logic                                   rise_s;
  logic [7:0]                             w_raw_s;
  logic                                   clamp_s;
  frame_cfg_t                             cfg_new_s;
  frame_cfg_t                             cfg_r;
  frame_cfg_t                             cfg_s;
  logic [1:0]                             err_r;
  logic [1:0]                             err_set_s;
  logic                                   done_r;
  logic                                   all_done_s;
  logic                                   drop_s;
  logic [NUM_KERNEL-1:0][BIT_WIDTH-1:0]   psum_s;
  logic [NUM_KERNEL-1:0]                  val_s;
  logic [NUM_KERNEL-1:0][ACC_WIDTH-1:0]   acc_s;
  logic [NUM_KERNEL-1:0]                  acc_val_s;
  logic [NUM_KERNEL-1:0]                  lane_done_s;
  logic [NUM_KERNEL-1:0]                  lane_active_s;
  logic                                   unused_cfg_bits;

  assign psum_s = {bus.i_psum_kn3, bus.i_psum_kn2, bus.i_psum_kn1, bus.i_psum_kn0};
  assign val_s  = {bus.i_psum_kn3_val, bus.i_psum_kn2_val, bus.i_psum_kn1_val, bus.i_psum_kn0_val};

  assign bus.o_acc_kn0     = acc_s[0];
  assign bus.o_acc_kn1     = acc_s[1];
  assign bus.o_acc_kn2     = acc_s[2];
  assign bus.o_acc_kn3     = acc_s[3];
  assign bus.o_acc_kn0_val = acc_val_s[0];
  assign bus.o_acc_kn1_val = acc_val_s[1];
  assign bus.o_acc_kn2_val = acc_val_s[2];
  assign bus.o_acc_kn3_val = acc_val_s[3];

  assign unused_cfg_bits = ^{i_conf_ctrl[REG_WIDTH-1:1],
                             i_conf_outputshape[REG_WIDTH-1:8],
                             i_conf_numpass[REG_WIDTH-1:8]};

  // Enable edge detection, width clamp and the geometry the lanes use this
  // cycle (the freshly latched value is forwarded on the enabling cycle).
  always_comb begin
    en_s    = i_conf_ctrl[CTRL_EN_BIT];
    rise_s  = en_s & ~en_d_r;
    w_raw_s = i_conf_outputshape[OSHAPE_MSB:OSHAPE_LSB];
    clamp_s = (w_raw_s > 8'(LINE_DEPTH-1));
    if (clamp_s) begin
      cfg_new_s.w = POS_WIDTH'(LINE_DEPTH-1);
    end else begin
      cfg_new_s.w = w_raw_s[POS_WIDTH-1:0];
    end
    cfg_new_s.p = i_conf_numpass[NUMPASS_MSB:NUMPASS_LSB];
    if (rise_s) begin
      cfg_s = cfg_new_s;
    end else begin
      cfg_s = cfg_r;
    end
    drop_s                = ~en_s & (|val_s);
    err_set_s             = 2'b00;
    err_set_s[ERR_DROP]   = drop_s;
    err_set_s[ERR_CLAMP]  = rise_s & clamp_s;
    all_done_s            = &lane_done_s;
  end

  // Config latch, sticky error flags and frame-done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_d_r <= 1'b0;
      cfg_r  <= '{w: {POS_WIDTH{1'b0}}, p: {PASS_WIDTH{1'b0}}};
      err_r  <= 2'b00;
      done_r <= 1'b0;
    end else begin
      en_d_r <= en_s;
      if (rise_s) begin
        cfg_r <= cfg_new_s;
      end
      err_r  <= err_r | err_set_s;
      done_r <= en_s & all_done_s;
    end
  end

  for (genvar g = 0; g < NUM_KERNEL; g++) begin : g_lane
    psum_lane_accumulator #(
      .BIT_WIDTH  (BIT_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .LINE_DEPTH (LINE_DEPTH),
      .POS_WIDTH  (POS_WIDTH),
      .PASS_WIDTH (PASS_WIDTH)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .en        (en_s),
      .psum      (psum_s[g]),
      .psum_val  (val_s[g]),
      .w         (cfg_s.w),
      .p         (cfg_s.p),
      .done_clr  (all_done_s),
      .acc       (acc_s[g]),
      .acc_val   (acc_val_s[g]),
      .lane_done (lane_done_s[g]),
      .active    (lane_active_s[g])
    );
  end

  assign o_done = done_r;
  assign o_busy = en_s & (|(lane_active_s | lane_done_s));
  assign o_err  = err_r;

endmodule

// File: tb/tb_psum_line_accumulator.sv
// Directed + randomized bench for psum_line_accumulator with a stream-index
// reference model: the n-th psum of a lane maps to a position/pass by plain
// division, and a final-pass output is the sum of the psums one line apart.
module tb_psum_line_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ctrl, oshape, npass;
  logic        o_done, o_busy;
  logic [1:0]  o_err;

  logic [7:0]  d [4];
  logic        v [4];
  logic [15:0] acc [4];
  logic        accv [4];

  int checks = 0;
  int errors = 0;

  // reference model state
  int  hist [4][$];
  int  mw, mp;
  bit  flag [4];
  bit  en_prev;
  bit  err0, err1;

  always #5 clk = ~clk;

  psum_line_accumulator_if bus ();

  assign bus.i_psum_kn0 = d[0];
  assign bus.i_psum_kn1 = d[1];
  assign bus.i_psum_kn2 = d[2];
  assign bus.i_psum_kn3 = d[3];
  assign bus.i_psum_kn0_val = v[0];
  assign bus.i_psum_kn1_val = v[1];
  assign bus.i_psum_kn2_val = v[2];
  assign bus.i_psum_kn3_val = v[3];
  assign acc[0] = bus.o_acc_kn0;
  assign acc[1] = bus.o_acc_kn1;
  assign acc[2] = bus.o_acc_kn2;
  assign acc[3] = bus.o_acc_kn3;
  assign accv[0] = bus.o_acc_kn0_val;
  assign accv[1] = bus.o_acc_kn1_val;
  assign accv[2] = bus.o_acc_kn2_val;
  assign accv[3] = bus.o_acc_kn3_val;

  psum_line_accumulator dut (
    .clk                (clk),
    .rst                (rst),
    .bus                (bus),
    .i_conf_ctrl        (ctrl),
    .i_conf_outputshape (oshape),
    .i_conf_numpass     (npass),
    .o_done             (o_done),
    .o_busy             (o_busy),
    .o_err              (o_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the current inputs for one clock, predict, then compare after the edge.
  task automatic step();
    bit          en, all, exp_done, busy;
    bit          exp_v [4];
    logic [15:0] exp_a [4];
    bit          fin [4];
    int          n, f, r, s;
    en = ctrl[0];
    if (en && !en_prev) begin
      mw = (oshape[7:0] > 8'd63) ? 63 : int'(oshape[7:0]);
      mp = int'(npass[7:0]);
      if (oshape[7:0] > 8'd63) err1 = 1'b1;
    end
    f = (mw + 1) * (mp + 1);
    all = flag[0] & flag[1] & flag[2] & flag[3];
    exp_done = en & all;
    for (int k = 0; k < 4; k++) begin
      exp_v[k] = 1'b0; exp_a[k] = 16'h0000; fin[k] = 1'b0;
      if (!en) begin
        if (v[k]) err0 = 1'b1;
        hist[k].delete();
      end else if (v[k]) begin
        n = hist[k].size();
        hist[k].push_back(int'($signed(d[k])));
        r = n % f;
        if (r / (mw + 1) == mp) begin
          s = 0;
          for (int j = 0; j <= mp; j++) s += hist[k][n - j * (mw + 1)];
          exp_v[k] = 1'b1;
          exp_a[k] = 16'(s);
        end
        fin[k] = (r == f - 1);
      end
    end
    busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!en) flag[k] = 1'b0;
      else flag[k] = fin[k] | (flag[k] & ~exp_done);
      if (en && ((hist[k].size() % f) != 0 || flag[k])) busy = 1'b1;
    end
    en_prev = en;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("acc_val%0d", k), 32'(accv[k]), 32'(exp_v[k]));
      if (exp_v[k]) chk($sformatf("acc%0d", k), 32'(acc[k]), 32'(exp_a[k]));
    end
    chk("done", 32'(o_done), 32'(exp_done));
    chk("busy", 32'(o_busy), 32'(busy));
    chk("err", 32'(o_err), {30'd0, err1, err0});
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < 4; k++) v[k] = 1'b0;
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic drive_all(input logic [7:0] val);
    for (int k = 0; k < 4; k++) begin d[k] = val; v[k] = 1'b1; end
    step();
  endtask

  task automatic configure(input int w, input int p);
    ctrl = 32'd0; idle(1);
    oshape = 32'(w); npass = 32'(p); ctrl = 32'd1;
  endtask

  // Synchronous reset; every output must be back at zero after one edge.
  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) v[k] = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      hist[k].delete(); flag[k] = 1'b0;
      chk($sformatf("rst_acc%0d", k), 32'(acc[k]), 32'd0);
      chk($sformatf("rst_val%0d", k), 32'(accv[k]), 32'd0);
    end
    err0 = 1'b0; err1 = 1'b0; en_prev = 1'b0;
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] seq [6];
    logic [7:0] vals6 [6];
    rst = 1'b0; ctrl = 32'd0; oshape = 32'd0; npass = 32'd0;
    mw = 0; mp = 0; en_prev = 1'b0; err0 = 1'b0; err1 = 1'b0;
    for (int k = 0; k < 4; k++) begin d[k] = 8'h00; v[k] = 1'b0; flag[k] = 1'b0; end
    do_reset();

    // single pass, W=3: outputs equal inputs, o_done after the last output
    configure(3, 0);
    for (int i = 1; i <= 4; i++) drive_all(8'(i));
    idle(3);

    // three passes, W=1, lane0 only: 14 and 27 on the final pass
    configure(1, 2);
    vals6 = '{8'd5, 8'd6, 8'd10, 8'd20, 8'hFF, 8'd1};
    for (int i = 0; i < 6; i++) begin
      d[0] = vals6[i]; v[0] = 1'b1; step();
    end
    idle(2);

    // W=0 back-to-back same address: 0x00FE then 0xFF00
    configure(0, 1);
    drive_all(8'h7F); drive_all(8'h7F); drive_all(8'h80); drive_all(8'h80);
    idle(2);

    // lane1 skewed three cycles behind identical data
    configure(2, 1);
    for (int i = 0; i < 6; i++) seq[i] = 8'($urandom);
    for (int t = 0; t < 9; t++) begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (k == 1) ? t - 3 : t;
        v[k] = (idx >= 0 && idx < 6);
        d[k] = (idx >= 0 && idx < 6) ? seq[idx] : 8'h00;
      end
      step();
    end
    idle(3);

    // disable mid-frame, psum on kn2 while disabled, then restart cleanly
    configure(3, 1);
    for (int i = 0; i < 5; i++) drive_all(8'($urandom));
    ctrl = 32'd0;
    for (int k = 0; k < 4; k++) v[k] = 1'b0;
    v[2] = 1'b1; d[2] = 8'($urandom); step();
    ctrl = 32'd1;
    for (int i = 0; i < 8; i++) drive_all(8'($urandom));
    idle(2);

    // oversize width clamps to 63
    configure(200, 0);
    for (int i = 0; i < 67; i++) drive_all(8'($urandom));
    idle(2);

    // randomized frames with random per-lane gaps
    for (int c = 0; c < 6; c++) begin
      configure(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
      for (int i = 0; i < 80; i++) begin
        for (int k = 0; k < 4; k++) begin
          v[k] = ($urandom % 4) != 0;
          d[k] = 8'($urandom);
        end
        step();
      end
    end

    // reset in the middle of a frame: no output or done afterwards
    configure(4, 1);
    for (int i = 0; i < 3; i++) drive_all(8'($urandom));
    do_reset();
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psum_line_accumulator.md
Name: psum_line_accumulator

Overview:
- Downstream neighbour of the line convolution engine. Consumes its four per-kernel psum streams (`o_psum_knX` / `o_psum_knX_val`).
- Accumulates psums across several passes (kernel rows / channel groups) per output position, using one line memory per kernel lane.
- Emits the finished, wide accumulated outputs per kernel and signals frame completion to the control logic.

Parameters:
- BIT_WIDTH, 8, width of each incoming psum (signed two's complement).
- ACC_WIDTH, 16, accumulator and output width.
- NUM_KERNEL, 4, number of kernel lanes (ports are fixed at 4).
- LINE_DEPTH, 64, maximum output positions per line, i.e. line memory depth per lane.
- POS_WIDTH, 6, log2(LINE_DEPTH).
- REG_WIDTH, 32, width of the config registers.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_psum_kn0..i_psum_kn3  in  BIT_WIDTH each  psum per kernel lane
- i_psum_kn0_val..i_psum_kn3_val  in  1 each  psum valid per lane
- o_acc_kn0..o_acc_kn3  out  ACC_WIDTH each  final accumulated value per lane
- o_acc_kn0_val..o_acc_kn3_val  out  1 each  final value valid (one-cycle pulse)
- o_done  out  1  one-cycle pulse when all lanes have finished the frame
- o_busy  out  1  a frame is in progress
- o_err  out  2  sticky errors: [0] psum dropped while disabled, [1] line width clamped
- i_conf_ctrl  in  REG_WIDTH  bit0 = enable
- i_conf_outputshape  in  REG_WIDTH  [7:0] = positions per line minus 1 (W)
- i_conf_numpass  in  REG_WIDTH  [7:0] = passes minus 1 (P)

Behaviour:
- Reset: all outputs are 0, all counters are 0, lane_done flags clear, o_err = 0. Memory contents are don't-care.
- Config latch: W and P are latched on the cycle enable rises 0->1. Changes while enabled are ignored.
- Width clamp: if W > LINE_DEPTH-1, use LINE_DEPTH-1 and set o_err[1].
- Enable low acts as a synchronous soft clear:
  - pos/pass counters and lane_done flags go to 0; output valids go to 0.
  - Any psum valid arriving while disabled is dropped and sets o_err[0].
  - o_err clears only on rst.
- Per lane k, on i_psum_knk_val in cycle T (lanes are fully independent; arrival skew is allowed):
  - s = sign-extended psum; a = pos_k, the position counter.
  - If pass_k == 0: acc = s; otherwise acc = mem_k[a] + s. The add wraps modulo 2^ACC_WIDTH (no saturation).
  - mem_k[a] <= acc.
  - If pass_k == P (this includes P == 0): o_acc_knk <= acc and o_acc_knk_val = 1 in cycle T+1. Otherwise no output.
  - pos_k advances; when pos_k == W it wraps to 0 and pass_k <= (pass_k == P) ? 0 : pass_k + 1.
  - A wrap at pass P sets lane_done_k in cycle T+1.
- Back-to-back access: memory read is combinational from a register array, so consecutive psums to the same address are correct. This covers W == 0.
- o_done:
  - High in the cycle after all four lane_done flags are set. In that same cycle all flags clear and the next frame may already be streaming.
  - A lane that finishes frame N while another lane is still in frame N must not be blocked. Its next-frame psums are accepted normally; its lane_done flag stays set until o_done.
- o_busy = enable & (any pos_k != 0 | any pass_k != 0 | any lane_done_k).
- rst mid-frame: everything returns to the reset state on the next edge. No o_done and no o_acc valid are produced for the aborted frame.

Decomposition:
- Shared package:
  - ACC_WIDTH default.
  - o_err bit indices: ERR_DROP = 0, ERR_CLAMP = 1.
  - Config field slices: ctrl enable bit, outputshape[7:0], numpass[7:0].
  - A sign-extend function.
- Sub-module psum_lane_accumulator, instantiated 4 times. It holds the line memory, the pos/pass counters, the adder, the output register and the lane_done flag.
- Top level holds the config latch, clamp/error logic, o_done/o_busy, and the lane instantiation.

Test Plan:
- P=0, W=3, all lanes send 1,2,3,4 on consecutive cycles -> o_acc 1,2,3,4 each one cycle after its input; o_done one cycle after the last valid output.
- P=2, W=1, lane0 sends 5,6 | 10,20 | 0xFF,1 -> no output during passes 0 and 1; outputs 14 then 27.
- P=1, W=0, lane0 sends back-to-back 0x7F,0x7F (all lanes the same) -> single output 0x00FE; then 0x80,0x80 -> 0xFF00.
- Lane1 skewed 3 cycles behind the others with identical data -> other lanes' outputs unaffected; o_done only after lane1's final output.
- Disable mid-frame, drive kn2 valid while disabled, re-enable -> o_err[0] = 1; the frame restarts at pos 0 / pass 0 with correct sums.
- Config W = 200 -> o_err[1] = 1 and wrap at position 63. rst mid-frame -> all outputs 0, no o_done.
